// File: rtl/product_display_sched.sv
// ============================================================================
//  Module      : product_display_sched
//  Description : Captures a signed product, feeds its magnitude to an external
//                binary-to-BCD converter, latches the digits and scans a
//                scrollable 4-symbol window onto a seven-segment display.
//                Optional macro LEAD_BLANK_EN enables leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_display_sched #(
  parameter int REFRESH_DIV   = 100000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] prod_in,
  input  logic        scroll_left,
  input  logic        scroll_right,
  output logic [15:0] bin_out,
  input  logic [3:0]  d4_in,
  input  logic [3:0]  d3_in,
  input  logic [3:0]  d2_in,
  input  logic [3:0]  d1_in,
  input  logic [3:0]  d0_in,
  output logic        valid,
  output logic [3:0]  anode,
  output logic [3:0]  sym
);

  localparam int c_REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYCLES);
  localparam logic [3:0] c_SYM_MINUS = 4'hA;
  localparam logic [3:0] c_SYM_BLANK = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  state_t               r_state, w_state_n;
  logic                 r_neg, w_neg_n;
  logic [15:0]          r_bin, w_bin_n;
  logic [c_SET_W-1:0]   r_settle, w_settle_n;
  logic                 r_valid, w_valid_n;
  logic [1:0]           r_w, w_w_n;
  logic [1:0]           r_wact, w_wact_n;
  logic [4:0][3:0]      r_dig, w_dig_n;
  logic [c_REF_W-1:0]   r_ref, w_ref_n;
  logic [1:0]           r_idx, w_idx_n;
  logic [3:0]           r_anode, w_anode_n;
  logic [3:0]           r_sym, w_sym_n;

  logic [16:0]          w_ext;
  logic [15:0]          w_mag;
  logic                 w_wrap;
  logic [4:1]           w_blank;
  logic [3:0]           w_sign;
  logic [2:0]           w_sel;

  // 17-bit negate so that -32768 maps cleanly to 32768
  assign w_ext = {prod_in[15], prod_in};
  assign w_mag = prod_in[15] ? 16'(17'd0 - w_ext) : prod_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_neg    <= 1'b0;
      r_bin    <= '0;
      r_settle <= '0;
      r_valid  <= 1'b0;
      r_w      <= 2'd0;
      r_wact   <= 2'd0;
      r_dig    <= '0;
      r_ref    <= '0;
      r_idx    <= 2'd0;
      r_anode  <= 4'b1111;
      r_sym    <= c_SYM_BLANK;
    end else begin
      r_state  <= w_state_n;
      r_neg    <= w_neg_n;
      r_bin    <= w_bin_n;
      r_settle <= w_settle_n;
      r_valid  <= w_valid_n;
      r_w      <= w_w_n;
      r_wact   <= w_wact_n;
      r_dig    <= w_dig_n;
      r_ref    <= w_ref_n;
      r_idx    <= w_idx_n;
      r_anode  <= w_anode_n;
      r_sym    <= w_sym_n;
    end
  end

  // Sequencer: load has priority over everything, scrolls act only in SHOW
  always_comb begin
    w_state_n  = r_state;
    w_neg_n    = r_neg;
    w_bin_n    = r_bin;
    w_settle_n = r_settle;
    w_valid_n  = r_valid;
    w_w_n      = r_w;
    w_dig_n    = r_dig;
    if (load) begin
      w_state_n  = S_CONV;
      w_neg_n    = prod_in[15];
      w_bin_n    = w_mag;
      w_settle_n = '0;
      w_valid_n  = 1'b0;
      w_w_n      = 2'd0;
    end else begin
      case (r_state)
        S_CONV: begin
          if (r_settle == c_SET_LAST) begin
            w_dig_n   = {d4_in, d3_in, d2_in, d1_in, d0_in};
            w_valid_n = 1'b1;
            w_state_n = S_SHOW;
          end else begin
            w_settle_n = r_settle + 1'b1;
          end
        end
        S_SHOW: begin
          if (scroll_left && !scroll_right && (r_w != 2'd2)) begin
            w_w_n = r_w + 2'd1;
          end else if (scroll_right && !scroll_left && (r_w != 2'd0)) begin
            w_w_n = r_w - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Scan timing; the window in use is only refreshed on a position change
  always_comb begin
    w_wrap    = (r_ref == c_REF_LAST);
    w_ref_n   = w_wrap ? '0 : r_ref + 1'b1;
    w_idx_n   = w_wrap ? r_idx + 2'd1 : r_idx;
    w_wact_n  = w_wrap ? w_w_n : r_wact;
    w_anode_n = ~(4'b0001 << w_idx_n);
  end

  always_comb begin
    w_blank = '0;
`ifdef LEAD_BLANK_EN
    w_blank[4] = (w_dig_n[4] == 4'd0);
    w_blank[3] = w_blank[4] && (w_dig_n[3] == 4'd0);
    w_blank[2] = w_blank[3] && (w_dig_n[2] == 4'd0);
    w_blank[1] = w_blank[2] && (w_dig_n[1] == 4'd0);
`endif
    w_sign  = w_neg_n ? c_SYM_MINUS : c_SYM_BLANK;
    w_sel   = {1'b0, w_idx_n} + {1'b0, w_wact_n};
    w_sym_n = c_SYM_BLANK;
    if (w_valid_n) begin
      case (w_sel)
        3'd0:    w_sym_n = w_dig_n[0];
        3'd1:    w_sym_n = w_blank[1] ? c_SYM_BLANK : w_dig_n[1];
        3'd2:    w_sym_n = w_blank[2] ? c_SYM_BLANK : w_dig_n[2];
        3'd3:    w_sym_n = w_blank[3] ? c_SYM_BLANK : w_dig_n[3];
        3'd4:    w_sym_n = w_blank[4] ? c_SYM_BLANK : w_dig_n[4];
        3'd5:    w_sym_n = w_sign;
        default: w_sym_n = c_SYM_BLANK;
      endcase
    end
  end

  assign bin_out = r_bin;
  assign valid   = r_valid;
  assign anode   = r_anode;
  assign sym     = r_sym;

endmodule

`default_nettype wire

// File: tb/tb_product_display_sched.sv
// ============================================================================
//  Module      : tb_product_display_sched
//  Description : Directed, table-driven bench for product_display_sched with
//                a behavioural BCD converter. Honours LEAD_BLANK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_display_sched;

  localparam int c_DIV    = 4;
  localparam int c_SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] prod_in = '0;
  logic        scroll_left = 1'b0;
  logic        scroll_right = 1'b0;
  logic [15:0] bin_out;
  logic [3:0]  d4_in, d3_in, d2_in, d1_in, d0_in;
  logic        valid;
  logic [3:0]  anode;
  logic [3:0]  sym;

  int n_checks = 0;
  int n_errors = 0;

  product_display_sched #(
    .REFRESH_DIV   (c_DIV),
    .SETTLE_CYCLES (c_SETTLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .prod_in      (prod_in),
    .scroll_left  (scroll_left),
    .scroll_right (scroll_right),
    .bin_out      (bin_out),
    .d4_in        (d4_in),
    .d3_in        (d3_in),
    .d2_in        (d2_in),
    .d1_in        (d1_in),
    .d0_in        (d0_in),
    .valid        (valid),
    .anode        (anode),
    .sym          (sym)
  );

  always #5 clk = ~clk;

  always_comb begin
    d4_in = 4'((int'(bin_out) / 10000) % 10);
    d3_in = 4'((int'(bin_out) / 1000) % 10);
    d2_in = 4'((int'(bin_out) / 100) % 10);
    d1_in = 4'((int'(bin_out) / 10) % 10);
    d0_in = 4'(int'(bin_out) % 10);
  end

  typedef struct {
    logic [15:0] prod;
    int          nl;
    int          nr;
    logic [15:0] bin;
    logic [15:0] s_lit;
    logic [15:0] s_blk;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input logic [15:0] lit, input logic [15:0] blk);
`ifdef LEAD_BLANK_EN
    pick = blk;
`else
    pick = lit;
`endif
  endfunction

  task automatic load_and_time(input logic [15:0] v, output int lat);
    @(negedge clk);
    load = 1'b1;
    prod_in = v;
    @(posedge clk);
    #1 load = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic scroll(input logic l, input logic r);
    @(negedge clk);
    scroll_left = l;
    scroll_right = r;
    @(negedge clk);
    scroll_left = 1'b0;
    scroll_right = 1'b0;
  endtask

  // Collect one full scan as {pos3,pos2,pos1,pos0}; unseen positions stay E
  task automatic scan(output logic [15:0] s);
    s = 16'hEEEE;
    repeat (9) @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      case (anode)
        4'b1110: s[3:0]   = sym;
        4'b1101: s[7:4]   = sym;
        4'b1011: s[11:8]  = sym;
        4'b0111: s[15:12] = sym;
        default: ;
      endcase
    end
  endtask

  // Wait for a fresh arrival of the given anode pattern, sampled at negedge
  task automatic wait_anode_arrival(input logic [3:0] pat);
    int n;
    n = 0;
    while (anode == pat && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (anode != pat && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("anode_arrival", {12'd0, anode}, {12'd0, pat});
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic [15:0] s;
    logic [3:0]  pat;

    vecs[0] = '{16'hFB2E, 0, 0, 16'd1234,  16'h1234, 16'h1234};
    vecs[1] = '{16'hFB2E, 2, 0, 16'd1234,  16'hA012, 16'hAF12};
    vecs[2] = '{16'hFB2E, 3, 0, 16'd1234,  16'hA012, 16'hAF12};
    vecs[3] = '{16'h8000, 2, 0, 16'h8000,  16'hA327, 16'hA327};
    vecs[4] = '{16'h8000, 0, 0, 16'h8000,  16'h2768, 16'h2768};
    vecs[5] = '{16'h0007, 2, 0, 16'd7,     16'hF000, 16'hFFFF};
    vecs[6] = '{16'h7FFF, 2, 1, 16'd32767, 16'h3276, 16'h3276};
    vecs[7] = '{16'hFFFF, 0, 2, 16'd1,     16'h0001, 16'hFFF1};
    vecs[8] = '{16'h0000, 1, 0, 16'd0,     16'h0000, 16'hFFFF};
    vecs[9] = '{16'hFC18, 2, 0, 16'd1000,  16'hA010, 16'hAF10};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_anode", {12'd0, anode}, 16'h000F);
    check("rst_sym", {12'd0, sym}, 16'h000F);
    check("rst_valid", {15'd0, valid}, 16'd0);
    check("rst_bin", bin_out, 16'd0);
    rst = 1'b0;

    // Reset asserted mid-conversion
    @(negedge clk);
    load = 1'b1;
    prod_in = 16'h04D2;
    @(negedge clk);
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_anode", {12'd0, anode}, 16'h000F);
    check("midrst_sym", {12'd0, sym}, 16'h000F);
    check("midrst_valid", {15'd0, valid}, 16'd0);
    check("midrst_bin", bin_out, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("postrst_valid", {15'd0, valid}, 16'd0);
    check("postrst_bin", bin_out, 16'd0);
    check("postrst_sym", {12'd0, sym}, 16'h000F);

    // Table-driven load / scroll / scan
    for (int v = 0; v < 10; v++) begin
      load_and_time(vecs[v].prod, lat);
      check($sformatf("v%0d_latency", v), 16'(lat), 16'(c_SETTLE + 1));
      check($sformatf("v%0d_bin", v), bin_out, vecs[v].bin);
      for (int k = 0; k < vecs[v].nl; k++) scroll(1'b1, 1'b0);
      for (int k = 0; k < vecs[v].nr; k++) scroll(1'b0, 1'b1);
      scan(s);
      check($sformatf("v%0d_scan", v), s, pick(vecs[v].s_lit, vecs[v].s_blk));
    end

    // From w=2 on -1000: step right, then both pulses together must hold w=1
    scroll(1'b0, 1'b1);
    scan(s);
    check("w1_scan", s, pick(16'h0100, 16'hF100));
    scroll(1'b1, 1'b1);
    scan(s);
    check("both_scroll_scan", s, pick(16'h0100, 16'hF100));

    // Second load during conversion supersedes the first
    @(negedge clk);
    load = 1'b1;
    prod_in = 16'h0007;
    @(negedge clk);
    prod_in = 16'h0009;
    @(posedge clk);
    #1 load = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        break;
      end
    end
    check("reload_latency", 16'(lat), 16'(c_SETTLE + 1));
    check("reload_bin", bin_out, 16'd9);
    scan(s);
    check("reload_scan", s, pick(16'h0009, 16'hFFF9));

    // Anode order and dwell time
    wait_anode_arrival(4'b1110);
    for (int p = 0; p < 4; p++) begin
      pat = ~(4'b0001 << p);
      check($sformatf("anode_pat%0d", p), {12'd0, anode}, {12'd0, pat});
      cnt = 0;
      while (anode == pat && cnt < 10) begin
        cnt++;
        @(negedge clk);
      end
      check($sformatf("anode_len%0d", p), 16'(cnt), 16'(c_DIV));
    end

    // Scroll mid-position takes effect only at the next position
    load_and_time(16'hFB2E, lat);
    repeat (9) @(negedge clk);
    wait_anode_arrival(4'b1110);
    check("mid_pre_sym", {12'd0, sym}, 16'h0004);
    scroll_left = 1'b1;
    @(negedge clk);
    scroll_left = 1'b0;
    cnt = 0;
    while (anode == 4'b1110 && cnt < 10) begin
      check("mid_hold_sym", {12'd0, sym}, 16'h0004);
      cnt++;
      @(negedge clk);
    end
    check("mid_next_anode", {12'd0, anode}, 16'h000D);
    check("mid_next_sym", {12'd0, sym}, 16'h0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
